// File: rtl/adxl362_sample_scheduler.sv
// ODR tick generator plus X/Y/Z[/temp] acquisition sequencer that owns the shared converter port.
// First conv_req one cycle after the tick; conv_req holds until conv_ack or timeout; ticks seen while busy are dropped and flagged.
module adxl362_sample_scheduler #(
    parameter int DIV_BASE    = 50000,
    parameter int ACK_TIMEOUT = 255,
    parameter int DATA_W      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [2:0]        odr,
    input  logic              temp_en,
    output logic              conv_req,
    output logic [1:0]        conv_axis,
    input  logic              conv_ack,
    input  logic [DATA_W-1:0] conv_data,
    output logic [DATA_W-1:0] sample_x,
    output logic [DATA_W-1:0] sample_y,
    output logic [DATA_W-1:0] sample_z,
    output logic [DATA_W-1:0] sample_temp,
    output logic              data_ready,
    output logic              busy,
    output logic              overrun,
    output logic              conv_err,
    input  logic              status_clr
);
    localparam int CNT_W = $clog2(DIV_BASE * 32);
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        GAP    = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                axis_q, axis_d;
    logic                      temp_en_q, temp_en_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                odr_q;
    logic [TO_W-1:0]           to_q, to_d;
    logic [3:0][DATA_W-1:0]    shadow_q, shadow_d;
    logic [3:0][DATA_W-1:0]    sample_q, sample_d;
    logic                      overrun_q, overrun_d;
    logic                      conv_err_q, conv_err_d;
    logic [CNT_W-1:0]          period_m1;
    logic                      odr_chg;
    logic                      tick;
    logic                      last_axis;
    logic                      to_err;

    always_comb begin
        case (odr_q)
            3'd0:    period_m1 = CNT_W'(DIV_BASE * 32 - 1);
            3'd1:    period_m1 = CNT_W'(DIV_BASE * 16 - 1);
            3'd2:    period_m1 = CNT_W'(DIV_BASE * 8 - 1);
            3'd3:    period_m1 = CNT_W'(DIV_BASE * 4 - 1);
            3'd4:    period_m1 = CNT_W'(DIV_BASE * 2 - 1);
            default: period_m1 = CNT_W'(DIV_BASE - 1);
        endcase
    end

    // A rate change restarts the period from zero rather than carrying over a stale count.
    assign odr_chg = (odr != odr_q);
    assign tick    = enable && !odr_chg && (cnt_q == period_m1);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!enable || odr_chg || tick) begin
            cnt_d = '0;
        end
    end

    assign last_axis = temp_en_q ? (axis_q == 2'd3) : (axis_q == 2'd2);

    always_comb begin
        state_d   = state_q;
        axis_d    = axis_q;
        temp_en_d = temp_en_q;
        to_d      = '0;
        shadow_d  = shadow_q;
        sample_d  = sample_q;
        to_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d   = REQ;
                    axis_d    = 2'd0;
                    temp_en_d = temp_en;
                end
            end
            REQ: begin
                if (conv_ack) begin
                    shadow_d[axis_q] = conv_data;
                    if (last_axis) begin
                        // Load the whole set on entry to COMMIT so it is valid alongside data_ready.
                        state_d     = COMMIT;
                        sample_d[0] = shadow_d[0];
                        sample_d[1] = shadow_d[1];
                        sample_d[2] = shadow_d[2];
                        if (temp_en_q) begin
                            sample_d[3] = shadow_d[3];
                        end
                    end else begin
                        state_d = GAP;
                    end
                end else if (to_q == TO_W'(ACK_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    to_err  = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            GAP: begin
                state_d = REQ;
                axis_d  = axis_q + 2'd1;
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A set event in the same cycle as status_clr keeps the flag set.
    assign overrun_d  = (tick && (state_q != IDLE)) || (overrun_q && !status_clr);
    assign conv_err_d = to_err || (conv_err_q && !status_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            axis_q     <= 2'd0;
            temp_en_q  <= 1'b0;
            cnt_q      <= '0;
            odr_q      <= 3'd0;
            to_q       <= '0;
            shadow_q   <= '0;
            sample_q   <= '0;
            overrun_q  <= 1'b0;
            conv_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            axis_q     <= axis_d;
            temp_en_q  <= temp_en_d;
            cnt_q      <= cnt_d;
            odr_q      <= odr;
            to_q       <= to_d;
            shadow_q   <= shadow_d;
            sample_q   <= sample_d;
            overrun_q  <= overrun_d;
            conv_err_q <= conv_err_d;
        end
    end

    assign conv_req    = (state_q == REQ);
    assign conv_axis   = axis_q;
    assign data_ready  = (state_q == COMMIT);
    assign busy        = (state_q != IDLE);
    assign overrun     = overrun_q;
    assign conv_err    = conv_err_q;
    assign sample_x    = sample_q[0];
    assign sample_y    = sample_q[1];
    assign sample_z    = sample_q[2];
    assign sample_temp = sample_q[3];

endmodule

// File: tb/tb_adxl362_sample_scheduler.sv
// Directed bench for adxl362_sample_scheduler: converter responder, data_ready scoreboard, timing checks.
`timescale 1ns/1ps
module tb_adxl362_sample_scheduler;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [2:0]    odr = 3'd5;
    logic          temp_en = 1'b1;
    logic          conv_req;
    logic [1:0]    conv_axis;
    logic          conv_ack = 1'b0;
    logic [DW-1:0] conv_data = '0;
    logic [DW-1:0] sample_x, sample_y, sample_z, sample_temp;
    logic          data_ready, busy, overrun, conv_err;
    logic          status_clr = 1'b0;

    adxl362_sample_scheduler #(
        .DIV_BASE   (10),
        .ACK_TIMEOUT(255),
        .DATA_W     (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .odr        (odr),
        .temp_en    (temp_en),
        .conv_req   (conv_req),
        .conv_axis  (conv_axis),
        .conv_ack   (conv_ack),
        .conv_data  (conv_data),
        .sample_x   (sample_x),
        .sample_y   (sample_y),
        .sample_z   (sample_z),
        .sample_temp(sample_temp),
        .data_ready (data_ready),
        .busy       (busy),
        .overrun    (overrun),
        .conv_err   (conv_err),
        .status_clr (status_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Converter responder: acks after ack_dly cycles of conv_req, returns data_tab[axis].
    logic [DW-1:0] data_tab [4];
    bit ack_on = 1'b1;
    int ack_dly = 0;
    int req_age = 0;
    int temp_acks = 0;
    always @(negedge clk) begin
        if (!conv_req) req_age = 0;
        conv_ack  = conv_req && ack_on && (req_age >= ack_dly);
        conv_data = data_tab[conv_axis];
        if (conv_req) req_age++;
        if (conv_ack && conv_axis == 2'd3) temp_acks++;
    end

    typedef struct packed {
        int            cyc;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [DW-1:0] z;
        logic [DW-1:0] t;
    } exp_t;
    exp_t sb_q[$];
    bit   sb_on = 1'b1;

    logic       prev_req = 1'b0;
    logic [1:0] prev_axis = 2'd0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (prev_req && conv_req) chk("axis_stable", conv_axis, prev_axis);
        prev_req  = conv_req;
        prev_axis = conv_axis;
        if (sb_on && data_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dr_unexpected cycle %0d got data_ready=1 want 0", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("dr_cycle", cyc, e.cyc);
                chk("dr_x", sample_x, e.x);
                chk("dr_y", sample_y, e.y);
                chk("dr_z", sample_z, e.z);
                chk("dr_t", sample_temp, e.t);
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_req_rise(input int limit, output int at);
        logic prev;
        prev = conv_req;
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (conv_req && !prev && conv_axis == 2'd0) begin
                at = cyc;
                break;
            end
            prev = conv_req;
        end
    endtask

    task automatic pulse_clr();
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog cycle %0d got timeout want finish", cyc);
        $fatal(1, "watchdog");
    end

    int e0, c0, r0, t1, t2, ta;
    initial begin
        data_tab[0] = 12'h111; data_tab[1] = 12'h222;
        data_tab[2] = 12'h333; data_tab[3] = 12'h444;
        @(negedge clk);
        chk("rst_conv_req", conv_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data_ready", data_ready, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_conv_err", conv_err, 0);
        chk("rst_sx", sample_x, 0);
        chk("rst_st", sample_temp, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: P=10, ack immediate, temp included; enable drops mid third sequence
        e0 = cyc;
        enable = 1'b1;
        for (int k = 0; k < 3; k++)
            sb_q.push_back('{e0 + 17 + 10 * k, 12'h111, 12'h222, 12'h333, 12'h444});
        wait_req_rise(20, t1);
        chk("t1_first_req", t1 - e0, 10);
        goto(e0 + 33);
        enable = 1'b0;
        goto(e0 + 50);
        chk("t1_idle", busy, 0);
        chk("t1_no_overrun", overrun, 0);

        // 2: tick periods per odr, and restart on odr change
        sb_on = 1'b0;
        temp_en = 1'b0;
        odr = 3'd0;
        enable = 1'b1;
        wait_req_rise(400, t1);
        wait_req_rise(400, t2);
        chk("odr0_period", t2 - t1, 320);
        odr = 3'd4;
        c0 = cyc;
        wait_req_rise(60, t1);
        wait_req_rise(60, t2);
        chk("odr4_restart", t1 - c0, 21);
        chk("odr4_period", t2 - t1, 20);
        odr = 3'd7;
        wait_req_rise(40, t1);
        wait_req_rise(40, t2);
        chk("odr7_period", t2 - t1, 10);
        goto(t2 + 3);
        odr = 3'd4;
        c0 = cyc;
        wait_req_rise(60, t1);
        chk("odr_midcount", t1 - c0, 21);
        enable = 1'b0;
        goto(cyc + 30);
        sb_on = 1'b1;

        // 3: ack delayed 4 cycles -> overrun on busy ticks, set beats clear
        odr = 3'd5;
        temp_en = 1'b1;
        ack_dly = 4;
        data_tab[0] = 12'h5A1; data_tab[1] = 12'h5A2;
        data_tab[2] = 12'h5A3; data_tab[3] = 12'h5A4;
        @(negedge clk);
        pulse_clr();
        e0 = cyc;
        enable = 1'b1;
        sb_q.push_back('{e0 + 33, 12'h5A1, 12'h5A2, 12'h5A3, 12'h5A4});
        sb_q.push_back('{e0 + 63, 12'h5A1, 12'h5A2, 12'h5A3, 12'h5A4});
        goto(e0 + 9);
        chk("t3_busy_before", busy, 0);
        goto(e0 + 10);
        chk("t3_busy_after", busy, 1);
        chk("t3_req", conv_req, 1);
        goto(e0 + 18);
        chk("t3_ovr_before", overrun, 0);
        goto(e0 + 20);
        chk("t3_ovr_set", overrun, 1);
        goto(e0 + 29);
        status_clr = 1'b1;
        goto(e0 + 30);
        status_clr = 1'b0;
        chk("t3_set_wins", overrun, 1);
        goto(e0 + 64);
        enable = 1'b0;
        goto(e0 + 80);
        pulse_clr();
        chk("t3_ovr_clr", overrun, 0);

        // 4: no ack -> 255-cycle timeout, conv_err, no commit
        ack_on = 1'b0;
        e0 = cyc;
        enable = 1'b1;
        goto(e0 + 12);
        enable = 1'b0;
        goto(e0 + 264);
        chk("t4_req_held", conv_req, 1);
        chk("t4_err_before", conv_err, 0);
        goto(e0 + 265);
        chk("t4_req_drop", conv_req, 0);
        chk("t4_err_set", conv_err, 1);
        chk("t4_idle", busy, 0);
        chk("t4_sx_kept", sample_x, 12'h5A1);
        chk("t4_st_kept", sample_temp, 12'h5A4);
        pulse_clr();
        chk("t4_err_clr", conv_err, 0);
        ack_on = 1'b1;

        // 5: temp skipped -> three requests, data_ready at T+6, temp retained
        temp_en = 1'b0;
        ack_dly = 0;
        data_tab[0] = 12'h7B1; data_tab[1] = 12'h7B2;
        data_tab[2] = 12'h7B3; data_tab[3] = 12'hEEE;
        ta = temp_acks;
        e0 = cyc;
        enable = 1'b1;
        sb_q.push_back('{e0 + 15, 12'h7B1, 12'h7B2, 12'h7B3, 12'h5A4});
        goto(e0 + 12);
        enable = 1'b0;
        goto(e0 + 30);
        chk("t5_no_temp_req", temp_acks, ta);
        chk("t5_idle", busy, 0);

        // 6: async reset during Y request, then a full period to the next sequence
        odr = 3'd0;
        temp_en = 1'b1;
        ack_dly = 4;
        data_tab[0] = 12'h6C1; data_tab[1] = 12'h6C2;
        data_tab[2] = 12'h6C3; data_tab[3] = 12'h6C4;
        repeat (2) @(negedge clk);
        e0 = cyc;
        enable = 1'b1;
        goto(e0 + 327);
        chk("t6_y_axis", conv_axis, 1);
        chk("t6_y_req", conv_req, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req", conv_req, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_sx", sample_x, 0);
        chk("t6_rst_sy", sample_y, 0);
        chk("t6_rst_sz", sample_z, 0);
        chk("t6_rst_st", sample_temp, 0);
        goto(e0 + 335);
        rst_n = 1'b1;
        r0 = cyc;
        sb_q.push_back('{r0 + 343, 12'h6C1, 12'h6C2, 12'h6C3, 12'h6C4});
        wait_req_rise(400, t1);
        chk("t6_restart", t1 - r0, 320);
        goto(r0 + 325);
        enable = 1'b0;
        goto(r0 + 360);

        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adxl362_sample_scheduler.md
Name: adxl362_sample_scheduler

Overview:
Synthesizable measurement sequencer for the ADXL362 model. It derives the output-data-rate (ODR) sample tick from the system clock and the 3-bit odr setting. On each tick it runs one acquisition sequence over the shared converter: X, Y, Z, then optionally temperature. It commits all results to the data registers as a single coherent set and pulses data-ready. It replaces the free-running per-rate ODR clocks with one counter-based scheduler that owns the converter port.

Parameters:
DIV_BASE, 50000, clk cycles per 400 Hz tick (20 MHz clk); must be >= 2
ACK_TIMEOUT, 255, max cycles conv_req may stay high without conv_ack before abort
DATA_W, 12, converter result width

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  measurement mode; ticks generated only while high
odr  input  3  rate select: 0=12.5, 1=25, 2=50, 3=100, 4=200, 5..7=400 Hz
temp_en  input  1  include temperature conversion in the sequence
conv_req  output  1  conversion request, held until acknowledged
conv_axis  output  2  0=X, 1=Y, 2=Z, 3=temp; stable while conv_req high
conv_ack  input  1  converter accepts the request; conv_data valid in the same cycle
conv_data  input  DATA_W  conversion result
sample_x, sample_y, sample_z, sample_temp  output  DATA_W each  committed results
data_ready  output  1  one-cycle pulse when a new set is committed
busy  output  1  high when state != IDLE
overrun  output  1  sticky: tick arrived while busy
conv_err  output  1  sticky: ack timeout occurred
status_clr  input  1  one-cycle pulse clears overrun and conv_err

Behaviour:
- Reset (rst_n low, async): all outputs 0, state IDLE, tick counter 0, shadow registers 0, timeout counter 0.
- Period P = DIV_BASE << (5 - odr) for odr 0..4; P = DIV_BASE for odr 5..7. Counter width = clog2(DIV_BASE*32).
- Tick counter: counts 0..P-1 while enable is high; tick fires in the cycle cnt == P-1, then cnt wraps to 0. With enable low, cnt is held at 0 and no tick fires.
- odr is registered internally (odr_q). When odr != odr_q, cnt is forced to 0 and no tick fires that cycle.
- FSM states: IDLE, REQ, GAP, COMMIT.
- IDLE: on tick, go to REQ with axis = X. conv_req rises the next cycle (tick at T gives conv_req high at T+1).
- REQ: conv_req high. On conv_ack, capture conv_data into shadow[axis].
  - If this was the last axis (Z when temp_en = 0, temp when temp_en = 1), go to COMMIT.
  - Otherwise go to GAP.
  - temp_en is sampled at sequence start and held for the whole sequence.
- GAP: conv_req low for exactly one cycle. Advance axis, return to REQ.
- COMMIT: sample regs load from shadow simultaneously and data_ready is high for this one cycle. Next state is IDLE. sample_temp is unchanged when temp was skipped.
- Timing with ack tied high and temp_en = 1: requests at T+1, T+3, T+5, T+7; data_ready at T+8. With temp_en = 0: data_ready at T+6.
- Timeout: the counter increments each REQ cycle without ack and resets on entering REQ. When it reaches ACK_TIMEOUT:
  - conv_req drops next cycle and conv_err is set;
  - FSM returns to IDLE with no COMMIT;
  - sample regs are unchanged.
- Overrun: a tick while state != IDLE sets overrun and the tick is discarded; the in-flight sequence continues.
- status_clr clears overrun and conv_err. If a set event and status_clr occur in the same cycle, set wins.
- enable falling mid-sequence: the sequence completes normally, including COMMIT. No new ticks are generated.
- odr change mid-sequence: does not affect the in-flight sequence; only the counter restarts.
- Handshake rule: conv_axis never changes while conv_req is high, and conv_req never drops before ack except on timeout.

Test Plan:
1. DIV_BASE=10, odr=5, enable=1, ack tied high, conv_data = 0x111/0x222/0x333/0x444 per axis, temp_en=1 -> first conv_req 10 cycles after enable. data_ready every 10 cycles, 8 cycles after each tick. Sample regs = 0x111, 0x222, 0x333, 0x444.
2. odr=0 -> tick period 320 cycles; odr=4 -> 20; odr=7 -> 10. Change odr mid-count -> next tick exactly P cycles after the change.
3. conv_ack delayed 4 cycles per request, P=10 -> overrun set on the second tick and one data_ready per completed sequence. status_clr -> overrun=0.
4. conv_ack never asserted -> conv_req falls after 255 cycles high, conv_err=1, data_ready never pulses, sample regs unchanged.
5. temp_en=0 -> only axes 0, 1, 2 requested, sample_temp retains its prior value, data_ready at T+6.
6. rst_n pulled low during Y request -> conv_req, busy, and all sample regs go to 0 immediately. After release the next sequence starts after a full period.
